// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: datapath control and byte-wide instruction memory bus of the fetch unit
// master = fetch unit: drives mem_req/mem_addr and presents pc, pc_plus4, instr, instr_valid, align_err
// slave  = datapath + memory: drives advance, redirect, redirect_pc, mem_rdata, mem_ack
interface instr_fetch_unit_if #(parameter int AW = 5);
  logic          advance;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_ack;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          align_err;
  modport master (
    input  advance, redirect, redirect_pc, mem_rdata, mem_ack,
    output mem_req, mem_addr, pc, pc_plus4, instr, instr_valid, align_err
  );
  modport slave (
    output advance, redirect, redirect_pc, mem_rdata, mem_ack,
    input  mem_req, mem_addr, pc, pc_plus4, instr, instr_valid, align_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: byte-serial fetch of big-endian 32-bit instructions, held valid until advance/redirect
// clk, rst_n (async active-low); bus (master): memory byte requests out, acks/bytes in,
// advance/redirect from the datapath, pc/pc_plus4/instr/instr_valid/align_err out
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_plus4;
  logic [23:0] shadow_q, shadow_d;
  logic        valid_q, valid_d, align_q, align_d;
  assign pc_plus4        = pc_q + 32'd4;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.align_err   = align_q;
  assign bus.mem_req     = state_q == FETCH;
  // byte address wraps inside the memory while pc keeps full width
  assign bus.mem_addr    = pc_q[AW-1:0] + AW'(cnt_q);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    align_d  = 1'b0;
    if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      cnt_d   = 2'd0;
      valid_d = 1'b0;
      state_d = FETCH;
      align_d = |bus.redirect_pc[1:0];
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (state_q == FETCH && bus.mem_ack) begin
      // cnt wraps back to 0 on the fourth byte
      cnt_d    = cnt_q + 2'd1;
      shadow_d = cnt_q == 2'd0 ? {bus.mem_rdata, shadow_q[15:0]} :
                 cnt_q == 2'd1 ? {shadow_q[23:16], bus.mem_rdata, shadow_q[7:0]} :
                                 {shadow_q[23:8], bus.mem_rdata};
      if (cnt_q == 2'd3) begin
        instr_d = {shadow_q, bus.mem_rdata};
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end else if (state_q == HOLD && bus.advance) begin
      pc_d    = pc_plus4;
      valid_d = 1'b0;
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      shadow_q <= 24'd0;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario tasks with an expected-{pc,instr} queue checked when instr_valid rises
module tb_instr_fetch_unit;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] mem [32];
  logic [63:0] sb [$];
  logic [63:0] exp_v;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.AW(AW)) bus ();
  instr_fetch_unit #(.RESET_PC(32'h0), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.instr_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    bus.redirect = 1'b1;
    bus.redirect_pc = tgt;
    bus.mem_ack = 1'b0;
    step();
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    bus.advance = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.mem_ack = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
    checks++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h expected %h", bus.instr, 32'h0); end
    checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.align_err !== 1'b0) begin fails++; $display("FAIL reset_align: got %b expected 0", bus.align_err); end
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", bus.mem_req); end
    rst_n = 1'b1;
    sb.push_back({32'h0, 32'h8C010004});
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'(k)) begin fails++; $display("FAIL first_addr: got req=%b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, k); end
      checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL first_early_valid: got %b expected 0", bus.instr_valid); end
      step();
    end
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL first_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    checks++; if (bus.pc_plus4 !== 32'h4) begin fails++; $display("FAIL first_pc_plus4: got %h expected %h", bus.pc_plus4, 32'h4); end
    checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL hold_req: got %b expected 0", bus.mem_req); end
  endtask

  task automatic test_wait_states();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    do_redirect(32'h0);
    checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1) begin fails++; $display("FAIL ws_restart: got v=%b req=%b expected v=0 req=1", bus.instr_valid, bus.mem_req); end
    sb.push_back({32'h0, 32'h8C010004});
    for (int i = 0; i < 7; i++) begin
      bus.mem_ack = pat[i];
      checks++; if (bus.mem_addr !== 5'(n) || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL ws_addr: got addr=%h v=%b expected addr=%h v=0", bus.mem_addr, bus.instr_valid, n); end
      step();
      n += int'(pat[i]);
    end
    bus.mem_ack = 1'b0;
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL ws_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
  endtask

  task automatic test_advance();
    int n;
    bus.mem_ack = 1'b1;
    bus.advance = 1'b1;
    step();
    bus.advance = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 32'h4 || bus.mem_addr !== 5'h4) begin fails++; $display("FAIL adv_state: got v=%b pc=%h addr=%h expected v=0 pc=4 addr=4", bus.instr_valid, bus.pc, bus.mem_addr); end
    checks++; if (bus.pc_plus4 !== 32'h8) begin fails++; $display("FAIL adv_pc_plus4: got %h expected %h", bus.pc_plus4, 32'h8); end
    sb.push_back({32'h4, 32'h00222020});
    wait_valid(n);
    checks++; if (n !== 4) begin fails++; $display("FAIL adv_latency: got %0d expected 4", n); end
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL adv_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
  endtask

  task automatic test_redirect();
    int n;
    do_redirect(32'h4);
    checks++; if (bus.align_err !== 1'b0) begin fails++; $display("FAIL rd_aligned_err: got %b expected 0", bus.align_err); end
    bus.mem_ack = 1'b1;
    step(); step();
    checks++; if (bus.mem_addr !== 5'h6) begin fails++; $display("FAIL rd_mid_addr: got %h expected %h", bus.mem_addr, 5'h6); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h16;
    step();
    bus.redirect = 1'b0; bus.mem_ack = 1'b0;
    checks++; if (bus.pc !== 32'h14 || bus.mem_addr !== 5'h14) begin fails++; $display("FAIL rd_target: got pc=%h addr=%h expected pc=14 addr=14", bus.pc, bus.mem_addr); end
    checks++; if (bus.align_err !== 1'b1 || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rd_align_pulse: got err=%b v=%b expected err=1 v=0", bus.align_err, bus.instr_valid); end
    step();
    checks++; if (bus.align_err !== 1'b0 || bus.mem_addr !== 5'h14) begin fails++; $display("FAIL rd_after: got err=%b addr=%h expected err=0 addr=14", bus.align_err, bus.mem_addr); end
    sb.push_back({32'h14, 32'hAABBCCDD});
    bus.mem_ack = 1'b1;
    wait_valid(n);
    checks++; if (n !== 4) begin fails++; $display("FAIL rd_latency: got %0d expected 4", n); end
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL rd_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
  endtask

  task automatic test_wrap_priority();
    int n;
    do_redirect(32'h1C);
    sb.push_back({32'h1C, 32'hDEADBEEF});
    bus.mem_ack = 1'b1;
    wait_valid(n);
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL wp_word1c: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    bus.advance = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h8;
    step();
    bus.advance = 1'b0; bus.redirect = 1'b0;
    checks++; if (bus.pc !== 32'h8 || bus.mem_addr !== 5'h8) begin fails++; $display("FAIL wp_priority: got pc=%h addr=%h expected pc=8 addr=8", bus.pc, bus.mem_addr); end
    sb.push_back({32'h8, 32'h11223344});
    wait_valid(n);
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL wp_word8: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    do_redirect(32'h1C);
    sb.push_back({32'h1C, 32'hDEADBEEF});
    bus.mem_ack = 1'b1;
    wait_valid(n);
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL wp_refetch: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    bus.advance = 1'b1;
    step();
    bus.advance = 1'b0;
    checks++; if (bus.pc !== 32'h20 || bus.pc_plus4 !== 32'h24) begin fails++; $display("FAIL wp_wrap_pc: got pc=%h p4=%h expected pc=20 p4=24", bus.pc, bus.pc_plus4); end
    sb.push_back({32'h20, 32'h8C010004});
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.mem_addr !== 5'(k)) begin fails++; $display("FAIL wp_wrap_addr: got %h expected %h", bus.mem_addr, k); end
      step();
    end
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL wp_wrap_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    do_redirect(32'hFFFF_FFFC);
    checks++; if (bus.pc_plus4 !== 32'h0 || bus.mem_addr !== 5'h1C) begin fails++; $display("FAIL wp_top_pc: got p4=%h addr=%h expected p4=0 addr=1c", bus.pc_plus4, bus.mem_addr); end
    sb.push_back({32'hFFFF_FFFC, 32'hDEADBEEF});
    bus.mem_ack = 1'b1;
    wait_valid(n);
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL wp_top_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
  endtask

  task automatic test_async_reset();
    do_redirect(32'h8);
    bus.mem_ack = 1'b1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL ar_immediate: got pc=%h v=%b req=%b expected pc=0 v=0 req=0", bus.pc, bus.instr_valid, bus.mem_req); end
    checks++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL ar_instr: got %h expected 0", bus.instr); end
    step();
    rst_n = 1'b1;
    sb.push_back({32'h0, 32'h8C010004});
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'(k)) begin fails++; $display("FAIL ar_addr: got req=%b addr=%h expected req=1 addr=%h", bus.mem_req, bus.mem_addr, k); end
      step();
    end
    exp_v = sb.pop_front();
    checks++; if (bus.instr_valid !== 1'b1 || {bus.pc, bus.instr} !== exp_v) begin fails++; $display("FAIL ar_word: got v=%b %h expected v=1 %h", bus.instr_valid, {bus.pc, bus.instr}, exp_v); end
    checks++; if (sb.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
    {mem[0], mem[1], mem[2], mem[3]}         = 32'h8C010004;
    {mem[4], mem[5], mem[6], mem[7]}         = 32'h00222020;
    {mem[8], mem[9], mem[10], mem[11]}       = 32'h11223344;
    {mem[20], mem[21], mem[22], mem[23]}     = 32'hAABBCCDD;
    {mem[28], mem[29], mem[30], mem[31]}     = 32'hDEADBEEF;
    test_reset();
    test_wait_states();
    test_advance();
    test_redirect();
    test_wrap_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name:
instr_fetch_unit

Overview:
- Byte-serial instruction fetch stage that sits directly upstream of the single-cycle MIPS-lite datapath.
- Owns the program counter and reads the 8-bit-wide instruction memory one byte per handshake.
- Assembles 4 bytes big-endian into a 32-bit word, then presents it with a valid flag until the datapath accepts it (advance) or redirects the PC (branch/jump/link target).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
AW, 5, instruction memory byte-address width (32-byte memory)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
advance  input  1  datapath consumed current instr; fetch pc+4
redirect  input  1  load redirect_pc (taken branch/jump/link)
redirect_pc  input  32  redirect target byte address
mem_req  output  1  byte read request to instruction memory
mem_addr  output  AW  byte address of current request
mem_rdata  input  8  read byte, valid when mem_ack=1
mem_ack  input  1  memory returns mem_rdata this cycle
pc  output  32  address of the word being fetched/presented
pc_plus4  output  32  pc+4, 32-bit wrap, combinational
instr  output  32  last fully assembled instruction word
instr_valid  output  1  instr corresponds to pc and is stable
align_err  output  1  one-cycle pulse: redirect target misaligned

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, instr=0, instr_valid=0, align_err=0, byte counter cnt=0, state=IDLE. mem_req=0 while in reset. Partially assembled bytes are discarded.
- States:
  - IDLE: entered only from reset. Goes to FETCH on the first rising edge after rst_n rises.
  - FETCH: mem_req=1, mem_addr=(pc[AW-1:0]+cnt) mod 2^AW. Addresses wrap inside the memory; pc itself is not truncated.
  - HOLD: mem_req=0. instr and instr_valid=1 stay stable.
- FETCH byte capture: on each edge with mem_ack=1, mem_rdata goes into shadow byte cnt and cnt increments.
  - Byte 0 maps to [31:24]; byte 3 maps to [7:0].
  - On the 4th ack, instr<=shadow word (with byte 3), instr_valid<=1, state<=HOLD, cnt<=0.
  - mem_ack=0 inserts wait states with no change.
  - mem_ack in IDLE or HOLD is ignored.
- HOLD and advance: advance=1 at an edge gives pc<=pc+4, instr_valid<=0, state<=FETCH. advance while instr_valid=0 is ignored.
- Redirect (highest priority, any state except reset):
  - Next edge: pc<={redirect_pc[31:2],2'b00}, cnt<=0, instr_valid<=0, state<=FETCH.
  - A mem_ack in the same cycle is discarded.
  - instr keeps its old value but is not valid.
- Simultaneous redirect+advance: redirect wins; pc does not take pc+4.
- align_err: 1 for exactly the cycle after the redirect edge if redirect_pc[1:0]!=0, else 0. The fetch still proceeds at the aligned address.
- Latency: with mem_ack held 1, instr_valid rises 4 edges after entering FETCH. Steady state is 5 cycles per instruction: 4 byte cycles plus 1 HOLD cycle with advance.
- All outputs are registered except mem_req, mem_addr and pc_plus4, which are combinational from state/pc/cnt.
- pc_plus4 at pc=32'hFFFF_FFFC is 0.

Test Plan:
- Reset/first fetch: mem[0..3]=8C,01,00,04, mem_ack=1. Release rst_n → mem_addr 0,1,2,3 on successive cycles; instr=32'h8C010004 and instr_valid=1 after 4th ack; pc=0, pc_plus4=4.
- Wait states: mem_ack pattern 1,0,0,1,1,0,1 → exactly 4 captures, same word assembled, instr_valid rises on the edge of the 4th ack; mem_addr holds during gaps.
- Advance: in HOLD, pulse advance with mem[4..7]=00,22,20,20 → instr_valid falls next cycle, pc=4, then instr=32'h00222020 after 4 acks.
- Redirect mid-fetch: after 2 acks at pc=4, redirect=1 with redirect_pc=32'h16 (misaligned) and mem_ack=1 in the same cycle → pc=32'h14, align_err pulses 1 cycle, the same-cycle byte is dropped, fetch restarts at mem_addr 0x14.
- Wrap and priority: pc=32'h1C, advance and redirect (target 8) together → pc=8, not 0x20. Separately, an advance from 0x1C → pc=0x20, mem_addr 0,1,2,3 (wrap).
- Async reset mid-fetch: drop rst_n between edges after 3 acks → instr_valid=0 and pc=RESET_PC immediately, mem_req=0; after release, a fresh 4-byte fetch from address 0.
